alu_req_arbiter: RTL and testbench

- Shares one 32-bit ALU datapath (AND/OR/XOR/ADD units with an enable pin) between NUM_REQ requesters.
- Uses round-robin arbitration with a single outstanding operation.
- Sequences the ALU enable and operand buses, then returns each result with the winning requester's ID over a valid/ready response channel.
- Sits between the instruction-issue logic and the ALU top.

---
 rtl/alu_req_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU datapath between NUM_REQ requesters,
// keeping a single operation in flight and returning results over valid/ready.
module alu_req_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*3-1:0]     req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     alu_enable,
  output logic [2:0]               alu_op,
  output logic [WIDTH-1:0]         alu_i_1,
  output logic [WIDTH-1:0]         alu_i_2,
  input  logic [WIDTH-1:0]         alu_o,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t            state_r, state_next_s;
  logic [ID_W-1:0]   ptr_r, gnt_r, gnt_s, cand_s;
  logic              found_s;
  logic [2:0]        op_s;
  logic [WIDTH-1:0]  a_s, b_s;
  logic [NUM_REQ-1:0] req_ready_s;

  logic              alu_enable_r;
  logic [2:0]        alu_op_r;
  logic [WIDTH-1:0]  alu_i_1_r, alu_i_2_r;
  logic              rsp_valid_r, rsp_err_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [WIDTH-1:0]  rsp_data_r;

  function automatic logic op_legal(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
    return (g == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (g + ID_W'(1));
  endfunction

  // Round-robin search from ptr_r upward, plus mux of the winner's operands.
  always_comb begin
    found_s     = 1'b0;
    gnt_s       = {ID_W{1'b0}};
    cand_s      = {ID_W{1'b0}};
    op_s        = 3'b000;
    a_s         = {WIDTH{1'b0}};
    b_s         = {WIDTH{1'b0}};
    req_ready_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s  = ID_W'((int'(ptr_r) + i) % NUM_REQ);
      gnt_s   = (!found_s && req_valid[cand_s]) ? cand_s : gnt_s;
      found_s = found_s | req_valid[cand_s];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      op_s = (gnt_s == ID_W'(k)) ? req_op[k*3 +: 3]         : op_s;
      a_s  = (gnt_s == ID_W'(k)) ? req_a[k*WIDTH +: WIDTH] : a_s;
      b_s  = (gnt_s == ID_W'(k)) ? req_b[k*WIDTH +: WIDTH] : b_s;
      // Ready is suppressed while reset is asserted so no handshake can complete.
      req_ready_s[k] = rst_n && (state_r == IDLE) && found_s && (gnt_s == ID_W'(k));
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_next_s = op_legal(op_s) ? EXEC : RESP;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Grant capture, ALU bus sequencing and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r        <= {ID_W{1'b0}};
      gnt_r        <= {ID_W{1'b0}};
      alu_enable_r <= 1'b0;
      alu_op_r     <= 3'b000;
      alu_i_1_r    <= {WIDTH{1'b0}};
      alu_i_2_r    <= {WIDTH{1'b0}};
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= {ID_W{1'b0}};
      rsp_data_r   <= {WIDTH{1'b0}};
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt_r <= gnt_s;
            if (op_legal(op_s)) begin
              alu_enable_r <= 1'b1;
              alu_op_r     <= op_s;
              alu_i_1_r    <= a_s;
              alu_i_2_r    <= b_s;
            end else begin
              // Illegal opcodes bypass the ALU entirely.
              rsp_valid_r <= 1'b1;
              rsp_id_r    <= gnt_s;
              rsp_data_r  <= {WIDTH{1'b0}};
              rsp_err_r   <= 1'b1;
            end
          end
        end
        EXEC: begin
          alu_enable_r <= 1'b0;
          alu_op_r     <= 3'b000;
          alu_i_1_r    <= {WIDTH{1'b0}};
          alu_i_2_r    <= {WIDTH{1'b0}};
          rsp_valid_r  <= 1'b1;
          rsp_id_r     <= gnt_r;
          rsp_data_r   <= alu_o;
          rsp_err_r    <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            ptr_r       <= next_ptr(gnt_r);
          end
        end
        default: begin
          alu_enable_r <= 1'b0;
          rsp_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign alu_enable = alu_enable_r;
  assign alu_op     = alu_op_r;
  assign alu_i_1    = alu_i_1_r;
  assign alu_i_2    = alu_i_2_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a behavioural ALU, a response scoreboard, a
// table of single-request vectors and hand-written multi-cycle sequences.
module tb_alu_req_arbiter;
  localparam int WIDTH = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_REQ-1:0] req_valid, req_ready;
  logic [NUM_REQ*3-1:0] req_op;
  logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
  logic alu_enable;
  logic [2:0] alu_op;
  logic [WIDTH-1:0] alu_i_1, alu_i_2, alu_o;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [ID_W-1:0] rsp_id;
  logic [WIDTH-1:0] rsp_data;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];

  alu_req_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_enable(alu_enable), .alu_op(alu_op),
    .alu_i_1(alu_i_1), .alu_i_2(alu_i_2), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference opcode semantics: returns {err, data}.
  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return {1'b0, a & b};
      3'b001:  return {1'b0, a | b};
      3'b010:  return {1'b0, a ^ b};
      3'b011:  return {1'b0, a + b};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Behavioural ALU: output only while enabled.
  logic [32:0] alu_res;
  always_comb begin
    alu_res = ref_op(alu_op, alu_i_1, alu_i_2);
    alu_o = alu_enable ? alu_res[31:0] : 32'h0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[id*3 +: 3] = op;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_valid[id] = 1'b1;
  endtask

  // Scoreboard monitor: pushes on accept, pops on response handshake, and
  // checks the ALU buses follow the last legal accept by one cycle.
  logic exp_en;
  logic [2:0] exp_op;
  logic [31:0] exp_a, exp_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_en = 1'b0; exp_op = 3'b000; exp_a = 32'h0; exp_b = 32'h0;
    end else begin
      chk("mon_alu_enable", alu_enable, exp_en);
      chk("mon_alu_op", alu_op, exp_op);
      chk("mon_alu_i_1", alu_i_1, exp_a);
      chk("mon_alu_i_2", alu_i_2, exp_b);
      chk("mon_ready_onehot", ($countones(req_ready) <= 1), 1'b1);
      chk("mon_ready_without_valid", req_ready & ~req_valid, 4'b0000);
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("mon_unexpected_rsp", 1'b1, 1'b0);
        end else begin
          rsp_t e;
          e = sb_q.pop_front();
          chk("sb_rsp_id", rsp_id, e.id);
          chk("sb_rsp_data", rsp_data, e.data);
          chk("sb_rsp_err", rsp_err, e.err);
        end
      end
      exp_en = 1'b0; exp_op = 3'b000; exp_a = 32'h0; exp_b = 32'h0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_ready[k]) begin
          logic [2:0] o;
          logic [31:0] a, b;
          logic [32:0] r;
          rsp_t n;
          o = req_op[k*3 +: 3];
          a = req_a[k*32 +: 32];
          b = req_b[k*32 +: 32];
          r = ref_op(o, a, b);
          n.id = 2'(k); n.data = r[31:0]; n.err = r[32];
          sb_q.push_back(n);
          if (!o[2]) begin
            exp_en = 1'b1; exp_op = o; exp_a = a; exp_b = b;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vec[8];
  int n, lat, cnt;
  int order[$];
  int when[$];
  logic seen_add;
  logic [31:0] held;

  initial begin
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    vec[0] = '{2'd0, 3'b000, 32'h0000129F, 32'h00000BD2, 32'h00000292, 1'b0};
    vec[1] = '{2'd1, 3'b001, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0};
    vec[2] = '{2'd2, 3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vec[3] = '{2'd3, 3'b011, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vec[4] = '{2'd2, 3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vec[5] = '{2'd1, 3'b101, 32'h00000123, 32'h00000456, 32'h00000000, 1'b1};
    vec[6] = '{2'd0, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vec[7] = '{2'd3, 3'b000, 32'hDEADBEEF, 32'hFFFF0000, 32'hDEAD0000, 1'b0};

    // Reset values.
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_alu_enable", alu_enable, 1'b0);
    chk("rst_alu_op", alu_op, 3'b000);
    chk("rst_alu_i_1", alu_i_1, 32'h0);
    chk("rst_alu_i_2", alu_i_2, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Table-driven single requests.
    for (int v = 0; v < 8; v++) begin
      req_valid = '0;
      drive_req(vec[v].id, vec[v].op, vec[v].a, vec[v].b);
      #1;
      n = 0;
      while (!req_ready[vec[v].id] && n < 10) begin tick(); #1; n++; end
      chk("tbl_accept", req_ready, 64'(4'b0001 << vec[v].id));
      tick();
      req_valid = '0;
      #1;
      lat = 1;
      while (!rsp_valid && lat < 10) begin tick(); #1; lat++; end
      chk("tbl_latency", lat, vec[v].exp_err ? 1 : 2);
      chk("tbl_rsp_id", rsp_id, vec[v].id);
      chk("tbl_rsp_data", rsp_data, vec[v].exp_data);
      chk("tbl_rsp_err", rsp_err, vec[v].exp_err);
      tick(); #1;
      chk("tbl_rsp_drop", rsp_valid, 1'b0);
    end

    // Round-robin with all four requesters valid.
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    drive_req(0, 3'b000, 32'h0F0F0F0F, 32'h00FF00FF);
    drive_req(1, 3'b001, 32'h11110000, 32'h00002222);
    drive_req(2, 3'b011, 32'hFFFFFFFF, 32'h00000001);
    drive_req(3, 3'b010, 32'hAAAAAAAA, 32'h55555555);
    seen_add = 1'b0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      #1;
      if (rsp_valid && rsp_id == 2'd2) begin
        seen_add = 1'b1;
        chk("rr_add_wrap", rsp_data, 32'h0);
      end
      for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) begin order.push_back(k); when.push_back(c); end
      tick();
    end
    req_valid = '0;
    chk("rr_grant_count", order.size(), 5);
    chk("rr_add_seen", seen_add, 1'b1);
    for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % 4);
    for (int i = 0; i + 1 < when.size(); i++) chk("rr_spacing", when[i+1] - when[i], 3);
    repeat (4) tick();

    // Backpressure with requesters 0 and 3 valid; last grant was 0, so 3 wins.
    rsp_ready = 1'b0;
    drive_req(0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00);
    drive_req(3, 3'b010, 32'h12345678, 32'hFFFFFFFF);
    #1;
    chk("bp_accept", req_ready, 4'b1000);
    tick(); #1;
    tick(); #1;
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    chk("bp_rsp_id", rsp_id, 2'd3);
    chk("bp_rsp_data", rsp_data, 32'hEDCBA987);
    held = rsp_data;
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, held);
      chk("bp_hold_id", rsp_id, 2'd3);
      chk("bp_no_ready", req_ready, 4'b0000);
      chk("bp_no_enable", alu_enable, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_accept_in_resp", req_ready, 4'b0000);
    tick(); #1;
    chk("wrap_grant0", req_ready, 4'b0001);
    chk("wrap_rsp_fell", rsp_valid, 1'b0);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Reset during EXEC; pointer is 1 here, so without reset 2 would win.
    drive_req(2, 3'b000, 32'hAAAA5555, 32'hFFFFFFFF);
    #1;
    chk("mid_accept", req_ready, 4'b0100);
    tick(); #1;
    chk("mid_exec_enable", alu_enable, 1'b1);
    chk("mid_exec_a", alu_i_1, 32'hAAAA5555);
    req_valid = '0;
    rst_n = 1'b0;
    tick(); #1;
    chk("mid_rst_enable", alu_enable, 1'b0);
    chk("mid_rst_op", alu_op, 3'b000);
    chk("mid_rst_i_1", alu_i_1, 32'h0);
    chk("mid_rst_i_2", alu_i_2, 32'h0);
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_id", rsp_id, 2'd0);
    chk("mid_rst_data", rsp_data, 32'h0);
    chk("mid_rst_err", rsp_err, 1'b0);
    chk("mid_rst_ready", req_ready, 4'b0000);
    rst_n = 1'b1;
    drive_req(0, 3'b001, 32'h00000F00, 32'h0000000F);
    drive_req(2, 3'b011, 32'h00000001, 32'h00000002);
    #1;
    chk("post_rst_grant0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rsp_valid) begin
        cnt++;
        chk("post_rst_rsp_id", rsp_id, 2'd0);
        chk("post_rst_rsp_data", rsp_data, 32'h00000F0F);
      end
      tick();
    end
    chk("post_rst_rsp_count", cnt, 1);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
